reaction_duel_ctrl: RTL
=======================

Name: reaction_duel_ctrl

Overview:
- Round sequencer for a two-player reaction game.
- Takes debounced single-cycle button pulses and a 1 ms tick enable (derived from clk upstream).
- Generates a pseudo-random arming delay, lights the LED, and times the race between players A and B in milliseconds.
- Arbitrates who stopped first, flags fouls, and presents a latched result to the 7-segment display path.

Parameters:
- TW, 11: width of reaction_time and the internal ms counter.
- MAX_MS, 1999: timeout value in ms. Must satisfy MAX_MS < 2**TW.
- MIN_DELAY_MS, 1000: fixed part of the arming delay in ms. Must be ≥1.
- RAND_BITS, 10: number of LFSR LSBs added to the delay (0 to RAND_BITS ≤ 11). RAND_BITS=0 gives a deterministic delay.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- clk, input, 1: 50 MHz system clock.
- clr, input, 1: asynchronous active-low reset.
- ms_tick, input, 1: one-cycle pulse every 1 ms.
- start, input, 1: debounced one-cycle start pulse.
- stop_a, input, 1: debounced one-cycle stop pulse, player A.
- stop_b, input, 1: debounced one-cycle stop pulse, player B.
- led, output, 1: go indicator, high only in RUN.
- busy, output, 1: high in ARM or RUN.
- done, output, 1: one-cycle pulse on entry to any end state.
- reaction_time, output, TW: latched winning time in ms.
- winner, output, 2: 01 = A, 10 = B, 11 = tie, 00 = none.
- foul, output, 2: bit0 = A fouled, bit1 = B fouled.
- timeout, output, 1: high in TOUT.
- state, output, 3: current state encoding, for display and debug.

Behaviour:
- Reset (clr=0, asynchronous):
  - State goes to IDLE; LFSR loads LFSR_SEED.
  - All outputs go to 0; internal counters go to 0.
- LFSR:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1.
  - Advances every clk in all states.
- States: IDLE=0, ARM=1, RUN=2, WIN=3, TOUT=4, FOUL=5. Encodings 6 and 7 are illegal and return to IDLE on the next clk.
- IDLE:
  - start → ARM on the next clk.
  - On that edge, dly_cnt loads MIN_DELAY_MS + LFSR[RAND_BITS-1:0].
  - Also on that edge, reaction_time, winner, foul and timeout clear to 0.
- ARM:
  - Each ms_tick decrements dly_cnt.
  - Any stop_a or stop_b → FOUL. foul captures {stop_b, stop_a} from that cycle, so simultaneous stops set both bits.
  - A stop takes priority over a same-cycle ms_tick expiry.
  - ms_tick with dly_cnt==1 and no stop → RUN. rt_cnt clears to 0 and led=1 from the next cycle.
- RUN:
  - Each ms_tick increments rt_cnt.
  - Any stop → WIN. reaction_time ← rt_cnt as it was before that cycle's tick (a same-cycle tick is not counted).
  - winner ← {stop_b, stop_a}; both stops in the same cycle gives a tie (11).
  - ms_tick with rt_cnt==MAX_MS and no stop → TOUT. reaction_time ← MAX_MS, winner=00, timeout=1.
- WIN, TOUT, FOUL:
  - led=0 and busy=0; results held stable.
  - Stops are ignored.
  - start → ARM exactly as from IDLE (new delay loaded, results cleared).
- start during ARM or RUN is ignored.
- done pulses for exactly one clk on the edge entering WIN, TOUT or FOUL.
- Width rules:
  - dly_cnt is 12 bits.
  - The delay sum MIN_DELAY_MS + (2**RAND_BITS − 1) must fit in 12 bits; this is checked at elaboration.
  - rt_cnt never exceeds MAX_MS.
- Reset mid-round: immediate return to IDLE; led drops asynchronously; no done pulse.

Decomposition:
- Shared package reaction_pkg holds:
  - state encodings ST_IDLE through ST_FOUL;
  - winner codes WIN_NONE, WIN_A, WIN_B, WIN_TIE;
  - the LFSR tap constant.
- One sub-module, rand_lfsr16 (clk, clr, seed param, q[15:0]), which is reusable by other game blocks.
- FSM, delay counter and ms counter stay in reaction_duel_ctrl.

Test Plan:
- RAND_BITS=0, MIN_DELAY_MS=3; start, then 3 ticks, then stop_a after 5 more ticks → led rises after the 3rd tick; WIN; reaction_time=5; winner=01; done pulses once.
- Same setup, stop_b pulsed after the 2nd arming tick → FOUL; foul=10; led never asserts; winner=00.
- In RUN after 7 ticks, stop_a and stop_b in the same cycle as the 8th tick → reaction_time=7, winner=11.
- MAX_MS=10; no stops in RUN → TOUT on the 11th tick; reaction_time=10; timeout=1; led=0.
- clr pulsed low mid-RUN (rt_cnt=4) → all outputs 0 immediately; state=0; no done pulse; a later start arms normally.
- From WIN, start → ARM on the next clk; reaction_time, winner and foul cleared; a second round measures an independent value (e.g. 12).

Source files
------------

// File: rtl/reaction_pkg.sv
// reaction_pkg: state encodings, winner codes and LFSR taps shared by the game blocks
package reaction_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_RUN  = 3'd2,
    ST_WIN  = 3'd3,
    ST_TOUT = 3'd4,
    ST_FOUL = 3'd5
  } state_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/rand_lfsr16.sv
// rand_lfsr16: free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1
module rand_lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        clr,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge clr)
    if (!clr) q <= SEED;
    else      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
endmodule

// File: rtl/reaction_duel_ctrl.sv
// reaction_duel_ctrl: two-player reaction game round sequencer with random arming delay
module reaction_duel_ctrl
  import reaction_pkg::*;
#(
  parameter int          TW           = 11,
  parameter int          MAX_MS       = 1999,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 10,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          ms_tick,
  input  logic          start,
  input  logic          stop_a,
  input  logic          stop_b,
  output logic          led,
  output logic          busy,
  output logic          done,
  output logic [TW-1:0] reaction_time,
  output logic [1:0]    winner,
  output logic [1:0]    foul,
  output logic          timeout,
  output logic [2:0]    state
);
  localparam logic [15:0] RMASK = 16'((32'd1 << RAND_BITS) - 1);
  if (MIN_DELAY_MS < 1 || RAND_BITS < 0 || RAND_BITS > 11 || MIN_DELAY_MS + (1 << RAND_BITS) - 1 > 4095)
    begin : g_bad_delay
      $error("reaction_duel_ctrl: arming delay does not fit in 12 bits");
    end
  if (MAX_MS >= (1 << TW) || LFSR_SEED == 16'h0000) begin : g_bad_param
    $error("reaction_duel_ctrl: MAX_MS must fit in TW bits and LFSR_SEED must be non-zero");
  end
  state_t          state_q, state_d;
  logic [11:0]     dly_q, dly_d;
  logic [TW-1:0]   rt_q, rt_d, rtime_q, rtime_d;
  logic [1:0]      win_q, win_d, foul_q, foul_d;
  logic            to_q, to_d, done_q, done_d;
  logic [15:0]     lfsr;
  logic [11:0]     dly_load;
  logic            any_stop;
  rand_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .clr(clr), .q(lfsr));
  assign dly_load = 12'(MIN_DELAY_MS) + 12'(lfsr & RMASK);
  assign any_stop = stop_a | stop_b;
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      rt_q    <= '0;
      rtime_q <= '0;
      win_q   <= WIN_NONE;
      foul_q  <= 2'b00;
      to_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      rt_q    <= rt_d;
      rtime_q <= rtime_d;
      win_q   <= win_d;
      foul_q  <= foul_d;
      to_q    <= to_d;
      done_q  <= done_d;
    end
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    rt_d    = rt_q;
    rtime_d = rtime_q;
    win_d   = win_q;
    foul_d  = foul_q;
    to_d    = to_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_WIN, ST_TOUT, ST_FOUL:
        if (start) begin
          state_d = ST_ARM;
          dly_d   = dly_load;
          rtime_d = '0;
          win_d   = WIN_NONE;
          foul_d  = 2'b00;
          to_d    = 1'b0;
        end
      ST_ARM:
        if (any_stop) begin
          state_d = ST_FOUL;
          foul_d  = {stop_b, stop_a};
          done_d  = 1'b1;
        end else if (ms_tick) begin
          dly_d = dly_q - 12'd1;
          if (dly_q == 12'd1) begin
            state_d = ST_RUN;
            rt_d    = '0;
          end
        end
      ST_RUN:
        if (any_stop) begin
          state_d = ST_WIN;
          rtime_d = rt_q;
          win_d   = {stop_b, stop_a};
          done_d  = 1'b1;
        end else if (ms_tick) begin
          if (rt_q == TW'(MAX_MS)) begin
            state_d = ST_TOUT;
            rtime_d = TW'(MAX_MS);
            win_d   = WIN_NONE;
            to_d    = 1'b1;
            done_d  = 1'b1;
          end else rt_d = rt_q + TW'(1);
        end
      default: state_d = ST_IDLE;
    endcase
  end
  assign led           = state_q == ST_RUN;
  assign busy          = state_q == ST_ARM || state_q == ST_RUN;
  assign done          = done_q;
  assign reaction_time = rtime_q;
  assign winner        = win_q;
  assign foul          = foul_q;
  assign timeout       = to_q;
  assign state         = state_q;
endmodule
